// File: rtl/inst_issue_queue.sv
// inst_issue_queue: in-order issue FIFO with a register scoreboard that holds
// the head back until every source/destination it touches has no pending write.
module inst_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [102:0]             in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [102:0]             out_inst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              busy_vec
);
  localparam int AW = $clog2(DEPTH);
  logic [102:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [31:0] busy, busy_set, busy_clr;
  logic [102:0] hd;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic rw, rs1_used, rs2_used, hazard, empty, enq, iss;
  assign hd  = mem[head];
  assign op  = hd[70:64];
  assign rs1 = hd[63:59];
  assign rs2 = hd[58:54];
  assign rd  = hd[53:49];
  assign rw  = hd[0];
  assign rs1_used = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign rs2_used = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  assign hazard = (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) | (rw & busy[rd]);
  assign empty = count == '0;
  // Full check uses registered count only, so a draining head never frees a slot early.
  assign in_ready  = (count < (AW+1)'(DEPTH)) & ~flush;
  assign out_valid = ~empty & ~hazard & ~flush;
  assign out_inst  = empty ? '0 : hd;
  assign enq = in_valid & in_ready;
  assign iss = out_valid & out_ready;
  assign busy_vec = busy;
  // Issue-set is applied after writeback-clear so a same-cycle collision stays busy.
  assign busy_set = (iss && rw && rd != 5'd0) ? (32'd1 << rd) : '0;
  assign busy_clr = wb_valid ? (32'd1 << wb_rd) : '0;
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= in_inst;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (iss) head <= head + 1'b1;
        count <= count + (AW+1)'(enq) - (AW+1)'(iss);
      end
    end
  end
endmodule

// File: doc/inst_issue_queue.md
INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  decoded instruction offered.
REQ-005 SHALL have port in_ready  output  1  queue can accept.
REQ-006 SHALL have port in_inst  input  103  packed decoded instruction, MSB to LSB: pc[31:0], opcode[6:0], rs1[4:0], rs2[4:0], rd[4:0], funct7[6:0], funct3[2:0], imm[31:0], MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite.
REQ-007 SHALL have port out_valid  output  1  head instruction issuable.
REQ-008 SHALL have port out_ready  input  1  execute stage accepts.
REQ-009 SHALL have port out_inst  output  103  head instruction, same packing as in_inst.
REQ-010 SHALL have port wb_valid  input  1  writeback completes.
REQ-011 SHALL have port wb_rd  input  5  writeback destination register.
REQ-012 SHALL have port flush  input  1  discard all queued entries.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-014 SHALL have port busy_vec  output  32  scoreboard, bit i = xi has pending write; bit 0 always 0.

Function
REQ-015 SHALL store entries in an in-order circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-016 SHALL drive in_ready = (count < DEPTH) & ~flush, from registered state only; no same-cycle enqueue into a full queue, even when the head is issuing.
REQ-017 SHALL enqueue in_inst at tail on in_valid & in_ready; count +1.
REQ-018 SHALL treat rs1 as used unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
REQ-019 SHALL treat rs2 as used only for opcode 0110011 (R), 0100011 (S) or 1100011 (B).
REQ-020 SHALL define head hazard = (rs1 used & busy[rs1]) | (rs2 used & busy[rs2]) | (RegWrite & busy[rd]), using registered busy; register 0 is never busy.
REQ-021 SHALL drive out_valid = (count != 0) & ~hazard & ~flush, combinationally; out_inst = head entry whenever count != 0, else all zeros.
REQ-022 SHALL issue on out_valid & out_ready: head advances, count -1, and busy[rd] set next cycle if RegWrite & rd != 0.
REQ-023 SHALL clear busy[wb_rd] next cycle on wb_valid; wb_rd = 0 is ignored.
REQ-024 SHALL give set priority when issue sets and writeback clears the same register in one cycle (busy stays 1).
REQ-025 SHALL not bypass: writeback clearing a register the head needs makes the head issuable the following cycle (1-cycle minimum wakeup latency).
REQ-026 SHALL handle simultaneous enqueue and issue with count unchanged, pointers both advance.
REQ-027 SHALL on flush: head=tail=0 and count=0 next cycle; no enqueue, no issue that cycle; busy_vec retained (in-flight writes still complete).
REQ-028 SHALL keep out_valid stable with out_inst unchanged while out_ready is low and no flush occurs.
REQ-029 SHALL enqueue-to-earliest-issue latency of 1 cycle (entry written at edge, visible at head the next cycle).

Reset
REQ-030 SHALL on rst_n low, asynchronously: pointers 0, count 0, busy_vec 0, entries' contents don't-care; out_valid 0, in_ready 1, out_inst 0.
REQ-031 SHALL resume normal operation on the first rising clk after rst_n deasserts; reset mid-operation discards all entries and busy state.

Verification
REQ-032 SHALL cover fill: DEPTH=4, 4 enqueues with out_ready=0 -> count=4, in_ready=0, 5th in_valid not accepted; then 1 issue -> in_ready=1 next cycle.
REQ-033 SHALL cover RAW: issue ADD x5 (RegWrite), then queued ADD x6,x5,x1 -> out_valid=0 until wb_valid wb_rd=5; out_valid=1 exactly one cycle after wb.
REQ-034 SHALL cover x0: instruction with rd=0 RegWrite issued -> busy_vec stays 0; follower reading x0 issues back-to-back.
REQ-035 SHALL cover set/clear collision: issue rd=7 while wb_valid wb_rd=7 same cycle -> busy_vec[7]=1 after.
REQ-036 SHALL cover flush with 3 entries and busy[9]=1 -> count=0, out_valid=0 next cycle, busy_vec[9]=1; in_valid during flush cycle not accepted.
REQ-037 SHALL cover wrap and reset: 10 enqueue/issue pairs at full throughput with DEPTH=4 -> in-order pc sequence preserved; rst_n pulse mid-stream -> count=0, busy_vec=0 immediately.
